apb_regbank: RTL and testbench



---
 rtl/apb_regbank.sv | 170 +++++++++++++++++
 tb/tb_apb_regbank.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_regbank.sv
// apb_regbank: APB slave register bank.
//   Map (byte offsets): 0x00 ID (RO), 0x04 CTRL (RW), 0x08 STATUS (W1C, set
//   by evt_i), 0x0C COUNT (RO free-running cycle counter), 0x10+4k GPk (RW).
// Ports:
//   aclk, aresetn               clock, asynchronous active-low reset
//   psel, penable, pwrite       APB control
//   paddr, pwdata, pstrb, pprot APB address / write data / byte strobes / protection
//   prdata, pready, pslverr     APB response (all combinational in the ready cycle)
//   evt_i                       per-bit STATUS set pulses
//   ctrl_o                      CTRL register contents
//   gp_o                        GP registers flattened, GP0 in the LSBs
module apb_regbank #(
    parameter int              ADDR_W      = 12,
    parameter int              DW          = 32,
    parameter int              NGP         = 4,
    parameter int              WAIT_STATES = 1,
    parameter logic [DW-1:0]   ID_VALUE    = DW'(32'hA9B0_0001),
    parameter int              PRIV_ONLY   = 0
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic [DW-1:0]       pwdata,
    input  logic [DW/8-1:0]     pstrb,
    input  logic [2:0]          pprot,
    output logic [DW-1:0]       prdata,
    output logic                pready,
    output logic                pslverr,
    input  logic [DW-1:0]       evt_i,
    output logic [DW-1:0]       ctrl_o,
    output logic [NGP*DW-1:0]   gp_o
);
    localparam int NB     = DW / 8;
    localparam int NWORDS = 4 + NGP;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t              state_q, state_d;
    logic [3:0]          wcnt_q, wcnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                write_q, write_d;

    logic [DW-1:0]       ctrl_q, status_q, status_d, count_q;
    logic [DW-1:0]       gp_q [NGP];

    logic [31:0]         word;
    logic                aligned, in_map, ro_hit, priv_fail, err, commit;
    logic [DW-1:0]       wmask, rd_val, clr_mask;
    logic                unused_ok;

    // Expand byte strobes into a bit mask.
    function automatic logic [DW-1:0] lane_mask(input logic [NB-1:0] strb);
        logic [DW-1:0] m;
        m = '0;
        for (int b = 0; b < NB; b++) begin
            m[b*8 +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                            input logic [DW-1:0] wdata,
                                            input logic [DW-1:0] m);
        return (old & ~m) | (wdata & m);
    endfunction

    assign pready = (state_q == ACCESS) && psel && penable &&
                    (wcnt_q == 4'(WAIT_STATES));

    // Decode always works from the address/direction captured at setup.
    always_comb begin
        word      = 32'(addr_q[ADDR_W-1:2]);
        aligned   = (addr_q[1:0] == 2'b00);
        in_map    = (word < 32'(NWORDS));
        ro_hit    = write_q && ((word == 32'd0) || (word == 32'd3));
        priv_fail = (PRIV_ONLY != 0) && !pprot[0];
        err       = !aligned || !in_map || ro_hit || priv_fail;
        commit    = pready && write_q && !err;
        wmask     = lane_mask(pstrb);
        rd_val    = '0;
        case (word)
            32'd0:   rd_val = ID_VALUE;
            32'd1:   rd_val = ctrl_q;
            32'd2:   rd_val = status_q;
            32'd3:   rd_val = count_q;
            default: begin
                for (int k = 0; k < NGP; k++) begin
                    if (word == 32'(4 + k)) rd_val = gp_q[k];
                end
            end
        endcase
    end

    assign prdata  = (pready && !write_q && !err) ? rd_val : '0;
    assign pslverr = pready && err;

    // Event set takes priority over a same-cycle W1C clear.
    always_comb begin
        clr_mask = (commit && (word == 32'd2)) ? (pwdata & wmask) : '0;
        status_d = (status_q & ~clr_mask) | evt_i;
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    state_d = ACCESS;
                    wcnt_d  = '0;
                    addr_d  = paddr;
                    write_d = pwrite;
                end
            end
            ACCESS: begin
                // Dropping psel aborts the transfer without commit.
                if (!psel || pready) begin
                    state_d = IDLE;
                end else if (penable) begin
                    wcnt_d = wcnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ctrl_q   <= '0;
            status_q <= '0;
            count_q  <= '0;
            for (int k = 0; k < NGP; k++) gp_q[k] <= '0;
        end else begin
            count_q  <= count_q + DW'(1);
            status_q <= status_d;
            if (commit && (word == 32'd1)) ctrl_q <= merge(ctrl_q, pwdata, wmask);
            for (int k = 0; k < NGP; k++) begin
                if (commit && (word == 32'(4 + k))) gp_q[k] <= merge(gp_q[k], pwdata, wmask);
            end
        end
    end

    assign ctrl_o = ctrl_q;

    for (genvar g = 0; g < NGP; g++) begin : g_flat
        assign gp_o[g*DW +: DW] = gp_q[g];
    end

    assign unused_ok = ^pprot[2:1];

endmodule

// File: tb/tb_apb_regbank.sv
module tb_apb_regbank;
    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         aresetn, psel, penable, pwrite;
    logic [11:0]  paddr;
    logic [31:0]  pwdata, evt;
    logic [3:0]   pstrb;
    logic [2:0]   pprot;

    logic [31:0]  prdata, ctrl_o;
    logic         pready, pslverr;
    logic [127:0] gp_o;

    logic [31:0]  prdata_z, ctrl_z;
    logic         pready_z, pslverr_z;
    logic [127:0] gp_z;

    int ncmp = 0;
    int nfail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Snapshot of the zero-wait, privileged-only instance in the first access cycle
    logic         rdy_z_first, err_z_first;
    logic [31:0]  rd_z_first;

    apb_regbank #(.WAIT_STATES(1)) dut (
        .aclk(clk), .aresetn(aresetn), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .evt_i(evt), .ctrl_o(ctrl_o), .gp_o(gp_o));

    apb_regbank #(.WAIT_STATES(0), .PRIV_ONLY(1)) dut_z (
        .aclk(clk), .aresetn(aresetn), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata_z), .pready(pready_z), .pslverr(pslverr_z),
        .evt_i(evt), .ctrl_o(ctrl_z), .gp_o(gp_z));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Starts at posedge+1, ends at posedge+1 with the bus idle, so calling it
    // twice in a row yields back-to-back transfers.
    task automatic xfer(input logic wr, input logic [11:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] ev_at_ready,
                        output logic [31:0] rd, output logic err,
                        output int waits, output int tr);
        int n;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        @(posedge clk);
        #1 penable = 1'b1;
        n = 0;
        @(negedge clk);
        rdy_z_first = pready_z;
        err_z_first = pslverr_z;
        rd_z_first  = prdata_z;
        while (!pready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("pready_seen", pready, 1'b1);
        rd = prdata; err = pslverr; waits = n; tr = cyc;
        evt = ev_at_ready;
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0; evt = '0;
    endtask

    logic [31:0] rd, c1, c2;
    logic        err;
    int          w, t1, t2;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; pprot = 3'b001; evt = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pready", pready, 1'b0);
        chk("rst_pslverr", pslverr, 1'b0);
        chk("rst_prdata", prdata, 32'h0);
        chk("rst_ctrl", ctrl_o, 32'h0);
        chk("rst_gp", gp_o, 128'h0);
        #2 aresetn = 1'b1;
        idle(1);

        // GP0 full write, one wait state
        xfer(1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 32'h0, rd, err, w, t1);
        chk("gp0_wr_waits", w, 1);
        chk("gp0_wr_err", err, 1'b0);
        chk("gp0_value", gp_o[31:0], 32'hDEADBEEF);
        chk("z_ready_first_cycle", rdy_z_first, 1'b1);
        chk("z_gp0_value", gp_z[31:0], 32'hDEADBEEF);
        xfer(1'b0, 12'h010, 32'h0, 4'h0, 32'h0, rd, err, w, t1);
        chk("gp0_rd", rd, 32'hDEADBEEF);
        chk("gp0_rd_err", err, 1'b0);

        // CTRL byte-lane write
        xfer(1'b1, 12'h004, 32'h12345678, 4'hF, 32'h0, rd, err, w, t1);
        xfer(1'b1, 12'h004, 32'h000000AA, 4'h1, 32'h0, rd, err, w, t1);
        chk("ctrl_lane0", ctrl_o, 32'h123456AA);
        xfer(1'b0, 12'h004, 32'h0, 4'h0, 32'h0, rd, err, w, t1);
        chk("ctrl_rd", rd, 32'h123456AA);

        // GP2 middle lanes only
        xfer(1'b1, 12'h018, 32'hFFFFFFFF, 4'h6, 32'h0, rd, err, w, t1);
        chk("gp2_lanes", gp_o[95:64], 32'h00FFFF00);

        // ID read; unprivileged on the privileged-only instance errors
        pprot = 3'b000;
        xfer(1'b0, 12'h000, 32'h0, 4'h0, 32'h0, rd, err, w, t1);
        chk("id_rd", rd, 32'hA9B00001);
        chk("id_rd_err", err, 1'b0);
        chk("z_priv_err", err_z_first, 1'b1);
        chk("z_priv_rdata", rd_z_first, 32'h0);
        pprot = 3'b001;

        // STATUS set / W1C, set wins
        evt = 32'h5;
        idle(1);
        evt = 32'h0;
        xfer(1'b0, 12'h008, 32'h0, 4'h0, 32'h0, rd, err, w, t1);
        chk("status_set", rd, 32'h5);
        xfer(1'b1, 12'h008, 32'h1, 4'hF, 32'h1, rd, err, w, t1);
        xfer(1'b0, 12'h008, 32'h0, 4'h0, 32'h0, rd, err, w, t1);
        chk("status_set_wins", rd, 32'h5);
        xfer(1'b1, 12'h008, 32'h4, 4'hF, 32'h0, rd, err, w, t1);
        xfer(1'b0, 12'h008, 32'h0, 4'h0, 32'h0, rd, err, w, t1);
        chk("status_w1c", rd, 32'h1);

        // Error responses
        xfer(1'b0, 12'h100, 32'h0, 4'h0, 32'h0, rd, err, w, t1);
        chk("oob_err", err, 1'b1);
        chk("oob_rdata", rd, 32'h0);
        xfer(1'b0, 12'h020, 32'h0, 4'h0, 32'h0, rd, err, w, t1);
        chk("past_gp_err", err, 1'b1);
        xfer(1'b0, 12'h006, 32'h0, 4'h0, 32'h0, rd, err, w, t1);
        chk("unaligned_err", err, 1'b1);
        chk("unaligned_rdata", rd, 32'h0);
        xfer(1'b1, 12'h000, 32'h12345678, 4'hF, 32'h0, rd, err, w, t1);
        chk("id_wr_err", err, 1'b1);
        xfer(1'b1, 12'h00C, 32'h0, 4'hF, 32'h0, rd, err, w, t1);
        chk("count_wr_err", err, 1'b1);
        xfer(1'b0, 12'h000, 32'h0, 4'h0, 32'h0, rd, err, w, t1);
        chk("id_unchanged", rd, 32'hA9B00001);
        xfer(1'b1, 12'h104, 32'hFFFFFFFF, 4'hF, 32'h0, rd, err, w, t1);
        chk("oob_wr_err", err, 1'b1);
        chk("oob_wr_no_side", gp_o, {32'h0, 32'h00FFFF00, 32'h0, 32'hDEADBEEF});

        // COUNT: pready edges 10 cycles apart
        xfer(1'b0, 12'h00C, 32'h0, 4'h0, 32'h0, c1, err, w, t1);
        idle(7);
        xfer(1'b0, 12'h00C, 32'h0, 4'h0, 32'h0, c2, err, w, t2);
        chk("count_gap", t2 - t1, 10);
        chk("count_delta", c2, c1 + 32'd10);

        // Abort: psel dropped before pready
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h01C;
        pwdata = 32'h11111111; pstrb = 4'hF;
        @(posedge clk);
        #1 penable = 1'b1;
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0;
        idle(2);
        chk("abort_gp3", gp_o[127:96], 32'h0);

        // Reset during an access to GP1
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h014;
        pwdata = 32'hCAFEF00D; pstrb = 4'hF;
        @(posedge clk);
        #1 penable = 1'b1;
        #2 aresetn = 1'b0;
        #1;
        chk("rst_mid_pready", pready, 1'b0);
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0;
        @(posedge clk);
        #1 aresetn = 1'b1;
        idle(1);
        chk("rst_mid_gp1", gp_o[63:32], 32'h0);
        chk("rst_mid_ctrl", ctrl_o, 32'h0);
        xfer(1'b1, 12'h014, 32'h0BADF00D, 4'hF, 32'h0, rd, err, w, t1);
        chk("post_rst_waits", w, 1);
        chk("post_rst_err", err, 1'b0);
        chk("post_rst_gp1", gp_o[63:32], 32'h0BADF00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
